// File: rtl/multicycle_control.sv
// Multicycle datapath sequencer: fetch/decode/execute/memory/writeback FSM
// with a retired-instruction counter plus halt and illegal-opcode status.
module multicycle_control #(
  parameter int OP_SIZE     = 6,
  parameter int ALUOP_SIZE  = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_SIZE-1:0]     opcode,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   pcWriteCond,
  output logic                   branchNe,
  output logic                   memGetData,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   irWrite,
  output logic                   regWrite,
  output logic [1:0]             regWriteDataSel,
  output logic                   aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [ALUOP_SIZE-1:0]  aluOP,
  output logic [1:0]             pcSrc,
  output logic                   halted,
  output logic                   illegalOp,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_LOAD_IMM  = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  localparam logic [OP_SIZE-1:0] OP_LOAD  = OP_SIZE'(32'h20);
  localparam logic [OP_SIZE-1:0] OP_STORE = OP_SIZE'(32'h21);
  localparam logic [OP_SIZE-1:0] OP_BEQ   = OP_SIZE'(32'h22);
  localparam logic [OP_SIZE-1:0] OP_BNE   = OP_SIZE'(32'h23);
  localparam logic [OP_SIZE-1:0] OP_JUMP  = OP_SIZE'(32'h24);
  localparam logic [OP_SIZE-1:0] OP_LI    = OP_SIZE'(32'h25);
  localparam logic [OP_SIZE-1:0] OP_HALT  = OP_SIZE'(32'h3F);

  localparam logic [ALUOP_SIZE-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_SIZE-1:0] ALU_SUB = ALUOP_SIZE'(1);

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] instret_reg;
  logic                   retire;
  logic                   is_rtype, is_imm;

  assign is_rtype = (opcode < OP_SIZE'(32'd16));
  assign is_imm   = (opcode >= OP_SIZE'(32'd16)) && (opcode < OP_SIZE'(32'd32));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire)
        instret_reg <= instret_reg + 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    retire          = 1'b0;
    pcWrite         = 1'b0;
    pcWriteCond     = 1'b0;
    branchNe        = 1'b0;
    memGetData      = 1'b0;
    memRead         = 1'b0;
    memWrite        = 1'b0;
    irWrite         = 1'b0;
    regWrite        = 1'b0;
    regWriteDataSel = 2'b00;
    aluSrcA         = 1'b0;
    aluSrcB         = 2'b00;
    aluOP           = ALU_ADD;
    pcSrc           = 2'b00;
    halted          = 1'b0;
    illegalOp       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
        if (memReady)
          state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        aluSrcB = 2'b10;
        if (is_rtype || is_imm)
          state_next = S_EXECUTE;
        else if (opcode == OP_LOAD || opcode == OP_STORE)
          state_next = S_MEM_ADDR;
        else if (opcode == OP_BEQ || opcode == OP_BNE)
          state_next = S_BRANCH;
        else if (opcode == OP_JUMP)
          state_next = S_JUMP;
        else if (opcode == OP_LI)
          state_next = S_LOAD_IMM;
        else if (opcode == OP_HALT)
          state_next = S_HALT;
        else begin
          illegalOp  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        if (opcode == OP_LOAD)
          state_next = S_MEM_READ;
        else if (opcode == OP_STORE)
          state_next = S_MEM_WRITE;
        else
          state_next = S_FETCH;
      end
      S_MEM_READ: begin
        memGetData = 1'b1;
        memRead    = 1'b1;
        if (memReady)
          state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        regWrite        = 1'b1;
        regWriteDataSel = 2'b01;
        state_next      = S_FETCH;
        retire          = 1'b1;
      end
      S_MEM_WRITE: begin
        memGetData = 1'b1;
        memWrite   = 1'b1;
        if (memReady) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXECUTE: begin
        aluSrcA    = 1'b1;
        aluSrcB    = is_rtype ? 2'b00 : 2'b10;
        aluOP      = ALUOP_SIZE'(opcode[3:0]);
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        regWrite   = 1'b1;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOP       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSrc       = 2'b01;
        branchNe    = (opcode == OP_BNE);
        state_next  = S_FETCH;
        retire      = 1'b1;
      end
      S_JUMP: begin
        pcWrite    = 1'b1;
        pcSrc      = 2'b10;
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_LOAD_IMM: begin
        regWrite        = 1'b1;
        regWriteDataSel = 2'b10;
        state_next      = S_FETCH;
        retire          = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase

    // Held reset silences every strobe so an in-flight access cannot complete.
    if (!rst_n) begin
      pcWrite         = 1'b0;
      pcWriteCond     = 1'b0;
      branchNe        = 1'b0;
      memGetData      = 1'b0;
      memRead         = 1'b0;
      memWrite        = 1'b0;
      irWrite         = 1'b0;
      regWrite        = 1'b0;
      regWriteDataSel = 2'b00;
      aluSrcA         = 1'b0;
      aluSrcB         = 2'b00;
      aluOP           = '0;
      pcSrc           = 2'b00;
      halted          = 1'b0;
      illegalOp       = 1'b0;
    end
  end

  assign state   = rst_n ? state_reg : 4'd0;
  assign instret = rst_n ? instret_reg : '0;

endmodule
